// File: rtl/ptn_sequencer_pkg.sv
// Shared definitions for the VGA pattern sequencer.
// Holds the sequencer FSM encoding and the default scroll limit.
// The scroll limit comes from the active line width minus the pattern tile width.
package ptn_sequencer_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int PTN_TILE_W   = 128;
    // The scroll limit keeps a full tile on screen at the right-hand edge.
    localparam int ANIM_MAX_DEF = H_ACTIVE - PTN_TILE_W;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_AUTO   = 2'd1,
        S_MANUAL = 2'd2
    } state_t;

endpackage

// File: rtl/ptn_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Latency: 2 sync cycles + DEB_CYCLES before the pulse; no backpressure.
// Ports: pck_i/rst_i clock and sync active-high reset, btn_i raw button, rise_o one-cycle pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic pck_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement (a glitch ending) restarts it at zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse is asserted in the cycle whose edge raises the debounced level.
    assign rise_o = level_d & ~level_q;

    always_ff @(posedge pck_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ptn_sequencer.sv
// Frame-synchronous pattern selector and scroll-offset generator for the VGA pattern datapath.
// Latency: FRAME_START one cycle after HCNT==VCNT==0; PTN_SEL/ANIM_OFS/AUTO_ACT change on that edge only.
// Ports: PCK/RST, VCNT/HCNT counters, BTN_NEXT/AUTO_EN/SPEED controls; PTN_SEL, ANIM_OFS, FRAME_START, AUTO_ACT out.
module ptn_sequencer
    import ptn_sequencer_pkg::*;
#(
    parameter int NUM_PTN        = 5,
    parameter int FRAMES_PER_PTN = 120,
    parameter int DEB_CYCLES     = 250000,
    parameter int ANIM_MAX       = ANIM_MAX_DEF
) (
    input  logic        PCK,
    input  logic        RST,
    input  logic [9:0]  VCNT,
    input  logic [9:0]  HCNT,
    input  logic        BTN_NEXT,
    input  logic        AUTO_EN,
    input  logic [1:0]  SPEED,
    output logic [2:0]  PTN_SEL,
    output logic [10:0] ANIM_OFS,
    output logic        FRAME_START,
    output logic        AUTO_ACT
);

    localparam logic [9:0]  FCNT_LAST = 10'(FRAMES_PER_PTN - 1);
    localparam logic [2:0]  PTN_LAST  = 3'(NUM_PTN - 1);
    localparam logic [10:0] OFS_MAX   = 11'(ANIM_MAX);

    logic        fs_raw;
    logic        fs_q;
    logic        auto_s1_q, auto_s2_q;
    logic        btn_rise;
    logic        adv;
    logic [10:0] ofs_sum;

    state_t      state_q, state_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic        pend_q, pend_d;
    logic [2:0]  ptn_q, ptn_d;
    logic [10:0] ofs_q, ofs_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .pck_i (PCK),
        .rst_i (RST),
        .btn_i (BTN_NEXT),
        .rise_o(btn_rise)
    );

    assign fs_raw  = (VCNT == 10'd0) && (HCNT == 10'd0);
    assign ofs_sum = ofs_q + {9'd0, SPEED};

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        ptn_d       = ptn_q;
        ofs_d       = ofs_q;
        // A press landing on a boundary edge is kept for the next boundary,
        // since the advance decision below only looks at the old pend_q.
        pend_d      = pend_q | btn_rise;
        adv         = 1'b0;

        if (fs_raw) begin
            if (state_q == S_INIT) begin
                // First boundary only chooses the mode; no advance or scroll.
                state_d     = auto_s2_q ? S_AUTO : S_MANUAL;
                frame_cnt_d = '0;
            end else begin
                adv = pend_q | ((state_q == S_AUTO) && (frame_cnt_q == FCNT_LAST));
                if (adv) begin
                    ptn_d       = (ptn_q == PTN_LAST) ? 3'd0 : ptn_q + 3'd1;
                    frame_cnt_d = '0;
                    ofs_d       = '0;
                    pend_d      = btn_rise;
                end else begin
                    if (state_q == S_AUTO) begin
                        frame_cnt_d = frame_cnt_q + 10'd1;
                    end
                    ofs_d = (ofs_sum > OFS_MAX) ? 11'd0 : ofs_sum;
                end
                state_d = auto_s2_q ? S_AUTO : S_MANUAL;
                if (auto_s2_q && (state_q != S_AUTO)) begin
                    frame_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge PCK) begin
        if (RST) begin
            fs_q        <= 1'b0;
            auto_s1_q   <= 1'b0;
            auto_s2_q   <= 1'b0;
            state_q     <= S_INIT;
            frame_cnt_q <= '0;
            pend_q      <= 1'b0;
            ptn_q       <= '0;
            ofs_q       <= '0;
        end else begin
            fs_q        <= fs_raw;
            auto_s1_q   <= AUTO_EN;
            auto_s2_q   <= auto_s1_q;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
            ptn_q       <= ptn_d;
            ofs_q       <= ofs_d;
        end
    end

    assign PTN_SEL     = ptn_q;
    assign ANIM_OFS    = ofs_q;
    assign FRAME_START = fs_q;
    assign AUTO_ACT    = (state_q == S_AUTO);

endmodule

// File: tb/tb_ptn_sequencer.sv
// Directed bench for ptn_sequencer on a small 16x8 raster (128 cycles per frame).
// DEB_CYCLES=8, FRAMES_PER_PTN=3, NUM_PTN=5, ANIM_MAX=10.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_ptn_sequencer;

    localparam int H_TOT = 16;
    localparam int V_TOT = 8;

    logic        PCK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  VCNT = 10'd0;
    logic [9:0]  HCNT = 10'd5;
    logic        BTN_NEXT = 1'b0;
    logic        AUTO_EN = 1'b1;
    logic [1:0]  SPEED = 2'd2;
    logic [2:0]  PTN_SEL;
    logic [10:0] ANIM_OFS;
    logic        FRAME_START;
    logic        AUTO_ACT;

    int errors = 0;
    int checks = 0;

    ptn_sequencer #(
        .NUM_PTN       (5),
        .FRAMES_PER_PTN(3),
        .DEB_CYCLES    (8),
        .ANIM_MAX      (10)
    ) dut (
        .PCK        (PCK),
        .RST        (RST),
        .VCNT       (VCNT),
        .HCNT       (HCNT),
        .BTN_NEXT   (BTN_NEXT),
        .AUTO_EN    (AUTO_EN),
        .SPEED      (SPEED),
        .PTN_SEL    (PTN_SEL),
        .ANIM_OFS   (ANIM_OFS),
        .FRAME_START(FRAME_START),
        .AUTO_ACT   (AUTO_ACT)
    );

    always #5 PCK = ~PCK;

    // Raster counter model, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge PCK);
            #1;
            if (HCNT == 10'(H_TOT - 1)) begin
                HCNT = 10'd0;
                VCNT = (VCNT == 10'(V_TOT - 1)) ? 10'd0 : VCNT + 10'd1;
            end else begin
                HCNT = HCNT + 10'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for the next FRAME_START, checks the outputs latched on that edge,
    // then checks the pulse has dropped one cycle later.
    task automatic boundary(input string tag, input int ptn, input int ofs, input int act);
        int n = 0;
        do begin
            @(negedge PCK);
            n++;
        end while (FRAME_START !== 1'b1 && n < 400);
        chk({tag, "_fs"}, 32'(FRAME_START), 32'd1);
        chk({tag, "_ptn"}, 32'(PTN_SEL), 32'(ptn));
        chk({tag, "_ofs"}, 32'(ANIM_OFS), 32'(ofs));
        chk({tag, "_act"}, 32'(AUTO_ACT), 32'(act));
        @(negedge PCK);
        chk({tag, "_fs_w"}, 32'(FRAME_START), 32'd0);
    endtask

    task automatic press(input int cycles);
        BTN_NEXT = 1'b1;
        repeat (cycles) @(negedge PCK);
        BTN_NEXT = 1'b0;
    endtask

    initial begin
        int prev;
        repeat (3) @(negedge PCK);
        RST = 1'b0;
        chk("rst_ptn", 32'(PTN_SEL), 32'd0);
        chk("rst_ofs", 32'(ANIM_OFS), 32'd0);
        chk("rst_fs", 32'(FRAME_START), 32'd0);
        chk("rst_act", 32'(AUTO_ACT), 32'd0);

        // Auto mode, SPEED=2: first boundary only enters S_AUTO.
        boundary("init", 0, 0, 1);
        boundary("a_f1", 0, 2, 1);
        boundary("a_f2", 0, 4, 1);
        boundary("a_adv1", 1, 0, 1);
        prev = 1;
        for (int k = 2; k <= 5; k++) begin
            boundary("a_s1", prev, 2, 1);
            boundary("a_s2", prev, 4, 1);
            boundary("a_adv", k % 5, 0, 1);
            prev = k % 5;
        end

        // Manual mode, SPEED=3 with ANIM_MAX=10: 3,6,9, hold at SPEED=0, then wrap.
        AUTO_EN = 1'b0;
        SPEED   = 2'd3;
        boundary("m_ofs3", 0, 3, 0);
        boundary("m_ofs6", 0, 6, 0);
        boundary("m_ofs9", 0, 9, 0);
        SPEED = 2'd0;
        boundary("m_frz1", 0, 9, 0);
        boundary("m_frz2", 0, 9, 0);
        SPEED = 2'd3;
        boundary("m_wrap", 0, 0, 0);
        SPEED = 2'd0;

        // Button: a 5-cycle glitch is rejected, a 20-cycle hold advances once.
        press(5);
        boundary("glitch", 0, 0, 0);
        press(20);
        boundary("btn_adv", 1, 0, 0);
        boundary("btn_once", 1, 0, 0);

        // Three clean presses inside one frame collapse to a single step.
        for (int p = 0; p < 3; p++) begin
            press(12);
            repeat (12) @(negedge PCK);
        end
        boundary("multi_adv", 2, 0, 0);
        boundary("multi_once", 2, 0, 0);

        // Back to auto; press lands in the frame before the auto advance.
        AUTO_EN = 1'b1;
        boundary("re_auto", 2, 0, 1);
        boundary("ra_f1", 2, 0, 1);
        boundary("ra_f2", 2, 0, 1);
        press(20);
        boundary("coinc_adv", 3, 0, 1);
        boundary("coinc_clr", 3, 0, 1);

        // Mid-frame reset during a half-debounced press.
        BTN_NEXT = 1'b1;
        repeat (6) @(negedge PCK);
        RST      = 1'b1;
        BTN_NEXT = 1'b0;
        AUTO_EN  = 1'b0;
        @(negedge PCK);
        RST = 1'b0;
        chk("mid_rst_ptn", 32'(PTN_SEL), 32'd0);
        chk("mid_rst_ofs", 32'(ANIM_OFS), 32'd0);
        chk("mid_rst_fs", 32'(FRAME_START), 32'd0);
        chk("mid_rst_act", 32'(AUTO_ACT), 32'd0);
        boundary("post_rst_init", 0, 0, 0);
        boundary("post_rst_nobtn", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
